dmux8way_gate: RTL and testbench

- 1-to-8 demultiplexer. Routes data input `in` to the one of outputs a..h chosen by `sel`; all other outputs are driven to 0.
- Sits in the gates library as a Hack-computer building block, used by RAM8 and larger memory address decoding.
- Adds a clocked per-channel activity monitor (sticky flags) for debug and verification.

---
 rtl/dmux_pkg.sv | 19 +
 rtl/dmux_decode3to8.sv | 26 ++
 rtl/dmux8way_gate.sv | 86 ++++++++
 tb/tb_dmux8way_gate.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared definitions for the 8-way demultiplexer: the select width, the
// channel count, the channel mask type and named channel indices.
package dmux_pkg;

   localparam int SEL_W  = 3;
   localparam int NUM_CH = 8;

   typedef logic [NUM_CH-1:0] ch_mask_t;

   localparam logic [SEL_W-1:0] CH_A = 3'd0;
   localparam logic [SEL_W-1:0] CH_B = 3'd1;
   localparam logic [SEL_W-1:0] CH_C = 3'd2;
   localparam logic [SEL_W-1:0] CH_D = 3'd3;
   localparam logic [SEL_W-1:0] CH_E = 3'd4;
   localparam logic [SEL_W-1:0] CH_F = 3'd5;
   localparam logic [SEL_W-1:0] CH_G = 3'd6;
   localparam logic [SEL_W-1:0] CH_H = 3'd7;

endpackage

// File: rtl/dmux_decode3to8.sv
// 3-to-8 one-hot decoder. Every select code is legal and maps to exactly
// one enable bit, so the enables never carry X for a known select.
module dmux_decode3to8
   import dmux_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   output ch_mask_t         en
);

   // Fully decode the select into a one-hot channel enable.
   always_comb begin
      en = 8'b0000_0000;
      case (sel)
         CH_A:    en = 8'b0000_0001;
         CH_B:    en = 8'b0000_0010;
         CH_C:    en = 8'b0000_0100;
         CH_D:    en = 8'b0000_1000;
         CH_E:    en = 8'b0001_0000;
         CH_F:    en = 8'b0010_0000;
         CH_G:    en = 8'b0100_0000;
         CH_H:    en = 8'b1000_0000;
         default: en = 8'b0000_0000;
      endcase
   end

endmodule

// File: rtl/dmux8way_gate.sv
// 1-to-8 demultiplexer with sticky per-channel activity flags.
// The selected output carries `in`, all others are zero. `act` records
// which channels have ever seen nonzero data since the last reset.
// Build option DMUX8WAY_GATE_OUT_REG_EN registers a..h (one cycle of
// latency, cleared by rst); without it the data path is combinational
// and independent of clk and rst.
module dmux8way_gate
   import dmux_pkg::*;
#(
   parameter int WIDTH = 1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] e,
   output logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] h,
   output logic [7:0]       act
);

   ch_mask_t                      en;
   logic                          in_active;
   logic [NUM_CH-1:0][WIDTH-1:0]  ch_data;

   dmux_decode3to8 u_decode (
      .sel (sel),
      .en  (en)
   );

   // Gate the data into each channel with that channel's one-hot enable.
   always_comb begin
      ch_data   = '0;
      in_active = |in;
      for (int k = 0; k < NUM_CH; k++) begin
         ch_data[k] = in & {WIDTH{en[k]}};
      end
   end

   // Sticky activity flags: set the selected channel's bit on nonzero data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act <= 8'h00;
      end else begin
         act <= act | (en & {NUM_CH{in_active}});
      end
   end

`ifdef DMUX8WAY_GATE_OUT_REG_EN
   logic [NUM_CH-1:0][WIDTH-1:0] out_q;

   // Capture the routed data so a..h change only on the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= ch_data;
      end
   end

   assign a = out_q[CH_A];
   assign b = out_q[CH_B];
   assign c = out_q[CH_C];
   assign d = out_q[CH_D];
   assign e = out_q[CH_E];
   assign f = out_q[CH_F];
   assign g = out_q[CH_G];
   assign h = out_q[CH_H];
`else
   assign a = ch_data[CH_A];
   assign b = ch_data[CH_B];
   assign c = ch_data[CH_C];
   assign d = ch_data[CH_D];
   assign e = ch_data[CH_E];
   assign f = ch_data[CH_F];
   assign g = ch_data[CH_G];
   assign h = ch_data[CH_H];
`endif

endmodule

// File: tb/tb_dmux8way_gate.sv
// Self-checking bench for dmux8way_gate: a 1-bit and an 8-bit instance
// share clock, reset and select. Expected outputs are pushed to a
// scoreboard when stimulus is applied and popped when outputs are sampled.
module tb_dmux8way_gate;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  sel = 3'd0;
   logic        in1 = 1'b0;
   logic [7:0]  in8 = 8'h00;

   logic        a1, b1, c1, d1, e1, f1, g1, h1;
   logic [7:0]  a8, b8, c8, d8, e8, f8, g8, h8;
   logic [7:0]  act1, act8;
   logic [7:0]  out1;
   logic [63:0] out8;

   typedef struct {
      logic [7:0]  e1;
      logic [63:0] e8;
   } exp_t;

   exp_t sb_q[$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign out1 = {h1, g1, f1, e1, d1, c1, b1, a1};
   assign out8 = {h8, g8, f8, e8, d8, c8, b8, a8};

   dmux8way_gate #(.WIDTH(1)) dut1 (
      .clk (clk), .rst (rst), .in (in1), .sel (sel),
      .a (a1), .b (b1), .c (c1), .d (d1), .e (e1), .f (f1), .g (g1), .h (h1),
      .act (act1)
   );

   dmux8way_gate #(.WIDTH(8)) dut8 (
      .clk (clk), .rst (rst), .in (in8), .sel (sel),
      .a (a8), .b (b8), .c (c8), .d (d8), .e (e8), .f (f8), .g (g8), .h (h8),
      .act (act8)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Wait until outputs reflect the newly driven inputs.
   task automatic settle();
`ifdef DMUX8WAY_GATE_OUT_REG_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
   endtask

   // Drive one pattern, push its expectation, then pop and compare.
   task automatic drive(input logic [2:0] s, input logic v1, input logic [7:0] v8);
      exp_t x;
      logic [7:0]  one;
      logic [63:0] wide;
      sel = s;
      in1 = v1;
      in8 = v8;
      one  = 8'h01;
      wide = {56'h0, v8};
      x.e1 = v1 ? (one << s) : 8'h00;
      x.e8 = wide << (int'(s) * 8);
      sb_q.push_back(x);
      settle();
      if (sb_q.size() == 0) begin
         chk("sb_empty", 64'd0, 64'd1);
      end else begin
         x = sb_q.pop_front();
         chk($sformatf("out1_sel%0d", s), {56'h0, out1}, {56'h0, x.e1});
         chk($sformatf("out8_sel%0d", s), out8, x.e8);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t x;
      // reset state
      #1;
      chk("act1_reset", {56'h0, act1}, 64'h00);
      chk("act8_reset", {56'h0, act8}, 64'h00);
      chk("out8_reset", out8, 64'h0);

      @(negedge clk);
      rst = 1'b0;

      // in=0 sweep: nothing routed, nothing flagged
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         drive(3'(s), 1'b0, 8'h00);
      end
      @(negedge clk);
      chk("act1_zero_sweep", {56'h0, act1}, 64'h00);
      chk("act8_zero_sweep", {56'h0, act8}, 64'h00);

      // nonzero sweep: one-hot routing on every code
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         drive(3'(s), 1'b1, 8'hA5);
      end
      @(negedge clk);
      chk("act1_all", {56'h0, act1}, 64'hFF);
      chk("act8_all", {56'h0, act8}, 64'hFF);

      // async reset between edges clears flags before the next edge
      @(negedge clk);
      sel = 3'd3;
      in1 = 1'b1;
      in8 = 8'hA5;
`ifdef DMUX8WAY_GATE_OUT_REG_EN
      x.e1 = 8'h00;
      x.e8 = 64'h0;
`else
      x.e1 = 8'h08;
      x.e8 = 64'h00000000_A5000000;
`endif
      sb_q.push_back(x);
      #1 rst = 1'b1;
      #1;
      chk("act1_async_rst", {56'h0, act1}, 64'h00);
      chk("act8_async_rst", {56'h0, act8}, 64'h00);
      x = sb_q.pop_front();
      chk("out1_in_rst", {56'h0, out1}, {56'h0, x.e1});
      chk("out8_in_rst", out8, x.e8);

      // activity flags: channel 2 then channel 6, then idle data
      @(negedge clk);
      rst = 1'b0;
      sel = 3'd2;
      in1 = 1'b1;
      in8 = 8'h01;
      @(negedge clk);
      chk("act1_ch2", {56'h0, act1}, 64'h04);
      chk("act8_ch2", {56'h0, act8}, 64'h04);
      sel = 3'd6;
      @(negedge clk);
      chk("act1_ch26", {56'h0, act1}, 64'h44);
      chk("act8_ch26", {56'h0, act8}, 64'h44);
      sel = 3'd0;
      in1 = 1'b0;
      in8 = 8'h00;
      @(negedge clk);
      chk("act1_hold", {56'h0, act1}, 64'h44);
      chk("act8_hold", {56'h0, act8}, 64'h44);

      // wide data moving from d to e
      @(negedge clk);
      drive(3'd3, 1'b0, 8'hA5);
      @(negedge clk);
      drive(3'd4, 1'b0, 8'hA5);
      @(negedge clk);
      chk("act8_de", {56'h0, act8}, 64'h5C);

`ifdef DMUX8WAY_GATE_OUT_REG_EN
      // registered outputs: b only rises after the next edge
      @(negedge clk);
      drive(3'd0, 1'b0, 8'h00);
      @(negedge clk);
      sel = 3'd1;
      in1 = 1'b1;
      #1;
      chk("b1_before_edge", {63'h0, b1}, 64'h0);
      @(posedge clk);
      #1;
      chk("b1_after_edge", {63'h0, b1}, 64'h1);
      rst = 1'b1;
      #1;
      chk("b1_rst_clear", {63'h0, b1}, 64'h0);
      rst = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
